// File: rtl/snn_layer_if.sv
// Bundles the per-window stimulus and winner-take-all result of snn_layer.
interface snn_layer_if #(
  parameter int NUM_SPIKES      = 16,
  parameter int LOG_NEURONS     = 2,
  parameter int LOG_TIME_PERIOD = 3
);
  logic                                        training;
  logic [LOG_TIME_PERIOD:0]                    time_val;
  logic [NUM_SPIKES*(LOG_TIME_PERIOD+1)-1:0]   spike_times;
  logic [LOG_TIME_PERIOD:0]                    output_spike_time;
  logic [LOG_NEURONS:0]                        winning_neuron;

  modport master (
    output training, time_val, spike_times,
    input  output_spike_time, winning_neuron
  );

  modport slave (
    input  training, time_val, spike_times,
    output output_spike_time, winning_neuron
  );
endinterface

// File: rtl/snn_layer.sv
// Spike-time-coded fully-connected layer with winner-take-all output.
// Optional STDP weight learning is built when the STDP_EN macro is defined.
module snn_layer #(
  parameter int NUM_SPIKES      = 16,
  parameter int NUM_NEURONS     = 4,
  parameter int LOG_NEURONS     = 2,
  parameter int WBITS           = 3,
  parameter int TIME_PERIOD     = 8,
  parameter int LOG_TIME_PERIOD = 3,
  parameter int THRESHOLD       = 16
) (
  input logic        clk,
  input logic        rst_l,
  snn_layer_if.slave bus
);
  localparam int TW = LOG_TIME_PERIOD + 1;
  localparam int PW = WBITS + $clog2(NUM_SPIKES) + 1;
  localparam int NW = LOG_NEURONS + 1;
  localparam logic [TW-1:0]    TP      = TW'(TIME_PERIOD);
  localparam logic [TW-1:0]    T_LAST  = TW'(TIME_PERIOD - 1);
  localparam logic [PW-1:0]    THR     = PW'(THRESHOLD);
  localparam logic [NW-1:0]    NO_WIN  = NW'(NUM_NEURONS);

  logic [TW-1:0]    spike_t  [NUM_SPIKES];
  logic [NUM_SPIKES-1:0] active;
  logic [WBITS-1:0] weight   [NUM_NEURONS][NUM_SPIKES];
  logic [PW-1:0]    potential[NUM_NEURONS];
  logic [TW-1:0]    ft_q     [NUM_NEURONS];
  logic [TW-1:0]    ft_d     [NUM_NEURONS];
  logic [TW-1:0]    ft_final [NUM_NEURONS];
  logic [NW-1:0]    win_idx;
  logic [TW-1:0]    win_time;
  logic [NW-1:0]    winner_q;
  logic [TW-1:0]    out_time_q;
  logic             window_end;
  logic             time_legal;

  assign window_end = (bus.time_val == T_LAST);
  assign time_legal = (bus.time_val < TP);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SPIKES; gi++) begin : g_input
      assign spike_t[gi] = bus.spike_times[gi*TW +: TW];
      assign active[gi]  = (spike_t[gi] < TP) && (spike_t[gi] <= bus.time_val);
    end
  endgenerate

  // Step-response potential: every input that has already spiked contributes its weight.
  always_comb begin
    for (int j = 0; j < NUM_NEURONS; j++) begin
      potential[j] = '0;
      for (int i = 0; i < NUM_SPIKES; i++) begin
        if (active[i]) potential[j] = potential[j] + PW'(weight[j][i]);
      end
    end
  end

  // ft_final folds in this cycle's crossing so the window-end decision sees it.
  always_comb begin
    for (int j = 0; j < NUM_NEURONS; j++) begin
      ft_final[j] = ft_q[j];
      if ((ft_q[j] == TP) && time_legal && (potential[j] >= THR)) ft_final[j] = bus.time_val;
      ft_d[j] = window_end ? TP : ft_final[j];
    end
  end

  // Strict less-than keeps the lowest index on ties.
  always_comb begin
    win_idx  = NO_WIN;
    win_time = TP;
    for (int j = 0; j < NUM_NEURONS; j++) begin
      if (ft_final[j] < win_time) begin
        win_idx  = NW'(j);
        win_time = ft_final[j];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      for (int j = 0; j < NUM_NEURONS; j++) ft_q[j] <= TP;
      winner_q   <= NO_WIN;
      out_time_q <= TP;
    end else begin
      for (int j = 0; j < NUM_NEURONS; j++) ft_q[j] <= ft_d[j];
      if (window_end) begin
        winner_q   <= win_idx;
        out_time_q <= win_time;
      end
    end
  end

  assign bus.winning_neuron    = winner_q;
  assign bus.output_spike_time = out_time_q;

`ifdef STDP_EN
  localparam logic [WBITS-1:0] WMAX = {WBITS{1'b1}};

  logic [WBITS-1:0] w_q [NUM_NEURONS][NUM_SPIKES];
  logic [WBITS-1:0] w_d [NUM_NEURONS][NUM_SPIKES];

  // Only the winner learns: causal inputs strengthen, late or silent ones weaken.
  always_comb begin
    w_d = w_q;
    if (bus.training && window_end && (win_idx != NO_WIN)) begin
      for (int j = 0; j < NUM_NEURONS; j++) begin
        if (NW'(j) == win_idx) begin
          for (int i = 0; i < NUM_SPIKES; i++) begin
            if ((spike_t[i] < TP) && (spike_t[i] <= win_time)) begin
              if (w_q[j][i] != WMAX) w_d[j][i] = w_q[j][i] + WBITS'(1);
            end else begin
              if (w_q[j][i] != '0) w_d[j][i] = w_q[j][i] - WBITS'(1);
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      for (int j = 0; j < NUM_NEURONS; j++)
        for (int i = 0; i < NUM_SPIKES; i++)
          w_q[j][i] <= WBITS'(i + 3*j);
    end else begin
      w_q <= w_d;
    end
  end

  assign weight = w_q;
`else
  genvar gk;
  generate
    for (gi = 0; gi < NUM_NEURONS; gi++) begin : g_wrow
      for (gk = 0; gk < NUM_SPIKES; gk++) begin : g_wcol
        assign weight[gi][gk] = WBITS'(gk + 3*gi);
      end
    end
  endgenerate
`endif
endmodule

// File: tb/tb_snn_layer.sv
// Directed bench for snn_layer: reset, inference, WTA tie-break, last-cycle firing, STDP, mid-window reset.
module tb_snn_layer;
  localparam int NS = 16;
  localparam int NN = 4;

  logic clk = 1'b0;
  logic rst_l;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   exp_w [NN][NS];

  snn_layer_if #(.NUM_SPIKES(NS), .LOG_NEURONS(2), .LOG_TIME_PERIOD(3)) bus ();

  snn_layer #(
    .NUM_SPIKES(NS), .NUM_NEURONS(NN), .LOG_NEURONS(2), .WBITS(3),
    .TIME_PERIOD(8), .LOG_TIME_PERIOD(3), .THRESHOLD(16)
  ) dut (
    .clk  (clk),
    .rst_l(rst_l),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic [63:0] spikes(input logic [15:0] mask, input int t);
    logic [63:0] v;
    for (int i = 0; i < NS; i++) v[i*4 +: 4] = mask[i] ? 4'(t) : 4'd8;
    return v;
  endfunction

  function automatic logic [63:0] dut_row(input int j);
    logic [63:0] v = '0;
    for (int i = 0; i < NS; i++) v[i*3 +: 3] = dut.weight[j][i];
    return v;
  endfunction

  function automatic logic [63:0] exp_row(input int j);
    logic [63:0] v = '0;
    for (int i = 0; i < NS; i++) v[i*3 +: 3] = 3'(exp_w[j][i]);
    return v;
  endfunction

  task automatic check_weights(input string tag);
    for (int j = 0; j < NN; j++) check($sformatf("%s_w%0d", tag, j), dut_row(j), exp_row(j));
  endtask

  task automatic check_out(input string tag, input int win, input int t);
    check({tag, "_winner"}, 64'(bus.winning_neuron), 64'(win));
    check({tag, "_time"}, 64'(bus.output_spike_time), 64'(t));
  endtask

  // Runs one full window; potentials are compared at time_val == probe (no probe if probe > 7).
  task automatic run_window(input string tag, input logic [63:0] st, input logic tr,
                            input int probe, input int p0, input int p1, input int p2, input int p3);
    int pe[NN];
    pe = '{p0, p1, p2, p3};
    bus.spike_times = st;
    bus.training    = tr;
    for (int t = 0; t < 8; t++) begin
      bus.time_val = 4'(t);
      #1;
      if (t == probe)
        for (int j = 0; j < NN; j++) check($sformatf("%s_p%0d", tag, j), 64'(dut.potential[j]), 64'(pe[j]));
      @(posedge clk);
      #1;
    end
    $display("window %s: training=%0d winner=%0d time=%0d", tag, tr, bus.winning_neuron, bus.output_spike_time);
  endtask

  initial begin
    for (int j = 0; j < NN; j++)
      for (int i = 0; i < NS; i++) exp_w[j][i] = (i + 3*j) % 8;

    rst_l           = 1'b0;
    bus.training    = 1'b0;
    bus.time_val    = '0;
    bus.spike_times = spikes(16'h0000, 0);
    repeat (2) @(posedge clk);
    #1;
    check_out("reset", 4, 8);
    check_weights("reset");
    rst_l = 1'b1;

    run_window("silent", spikes(16'h0000, 0), 1'b0, 99, 0, 0, 0, 0);
    check_out("silent", 4, 8);

    run_window("all_t0", spikes(16'hFFFF, 0), 1'b0, 0, 56, 56, 56, 56);
    check_out("all_t0", 0, 0);

    run_window("in567_t3", spikes(16'h00E0, 3), 1'b0, 3, 18, 3, 12, 13);
    check_out("in567_t3", 0, 3);
    check_weights("infer");

    run_window("n3_wins", spikes(16'h4048, 2), 1'b0, 2, 15, 8, 9, 18);
    check_out("n3_wins", 3, 2);

    run_window("last_cycle", spikes(16'h00E0, 7), 1'b0, 7, 18, 3, 12, 13);
    check_out("last_cycle", 0, 7);

    run_window("subthresh", spikes(16'h0001, 0), 1'b0, 0, 0, 3, 6, 1);
    check_out("subthresh", 4, 8);

    run_window("train", spikes(16'h00E0, 3), 1'b1, 3, 18, 3, 12, 13);
    check_out("train", 0, 3);
`ifdef STDP_EN
    exp_w[0] = '{0, 0, 1, 2, 3, 6, 7, 7, 0, 0, 1, 2, 3, 4, 5, 6};
    run_window("post_train", spikes(16'h00E0, 3), 1'b0, 3, 20, 3, 12, 13);
`else
    run_window("post_train", spikes(16'h00E0, 3), 1'b0, 3, 18, 3, 12, 13);
`endif
    check_weights("trained");
    check_out("post_train", 0, 3);

    // Reset pulsed mid-window must restore initial weights and outputs.
    bus.spike_times = spikes(16'h00E0, 3);
    bus.training    = 1'b1;
    for (int t = 0; t < 8; t++) begin
      bus.time_val = 4'(t);
      #1;
      if (t == 4) begin
        rst_l = 1'b0;
        #1;
        for (int j = 0; j < NN; j++)
          for (int i = 0; i < NS; i++) exp_w[j][i] = (i + 3*j) % 8;
        check_weights("midrst");
        check_out("midrst", 4, 8);
        rst_l = 1'b1;
        bus.spike_times = spikes(16'h0000, 0);
        bus.training    = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    $display("window midrst: winner=%0d time=%0d", bus.winning_neuron, bus.output_spike_time);
    check_out("after_midrst", 4, 8);

    run_window("reinfer", spikes(16'h00E0, 3), 1'b0, 3, 18, 3, 12, 13);
    check_out("reinfer", 0, 3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/snn_layer.md
Name:
snn_layer

Overview:
- Single fully-connected layer of a temporal (spike-time-coded) neural network with winner-take-all (WTA) output and optional on-chip STDP learning.
- Each input line carries one spike time per computation window. A shared external counter time_val defines the window.
- Each neuron accumulates the weights of inputs that have already spiked and fires when its potential reaches threshold. The earliest neuron to fire wins, and its index and fire time are reported once per window.

Parameters:
- NUM_SPIKES, 16, number of input synapses per neuron.
- NUM_NEURONS, 4, number of neurons in the layer.
- LOG_NEURONS, 2, clog2(NUM_NEURONS).
- WBITS, 3, weight width (unsigned).
- TIME_PERIOD, 8, window length in cycles. A time value >= TIME_PERIOD means "no spike".
- LOG_TIME_PERIOD, 3, clog2(TIME_PERIOD).
- THRESHOLD, 16, firing threshold (unsigned).

Ports:
- clk, input, 1, single clock, rising edge.
- rst_l, input, 1, asynchronous active-low reset.
- training, input, 1, 1 = apply STDP weight update at end of each window; 0 = inference only.
- time_val, input, LOG_TIME_PERIOD+1, current cycle within window; counts 0..TIME_PERIOD-1 then wraps to 0.
- spike_times, input, NUM_SPIKES x (LOG_TIME_PERIOD+1) packed, per-input spike time for the current window.
- output_spike_time, output, LOG_TIME_PERIOD+1, registered fire time of the winning neuron for the last completed window.
- winning_neuron, output, LOG_NEURONS+1, registered index of the winner for the last completed window; NUM_NEURONS = no winner.

Behaviour:
- Interface: one clock, clk. Reset rst_l is asynchronous and active-low.
- Reset values:
  - All potentials 0; all per-neuron fire times = TIME_PERIOD.
  - output_spike_time = TIME_PERIOD; winning_neuron = NUM_NEURONS.
  - Weights w[j][i] = (i + 3*j) mod 2^WBITS.
- Reset asserted mid-window discards all state, including learned weights.
- Input i is "active" in a cycle when spike_times[i] < TIME_PERIOD and spike_times[i] <= time_val.
- Potential of neuron j (combinational, step response, no leak):
  - P[j] = sum of w[j][i] over active inputs.
  - Width WBITS + clog2(NUM_SPIKES) + 1; the sum never overflows.
- Fire-time register per neuron (ft[j]):
  - Cleared to TIME_PERIOD on the edge where time_val == TIME_PERIOD-1, i.e. a new window starts.
  - Otherwise, if ft[j] == TIME_PERIOD and P[j] >= THRESHOLD, ft[j] <= time_val. Only the first crossing is recorded.
- End of window (edge where time_val == TIME_PERIOD-1):
  - Final fire times include that cycle's crossing.
  - WTA picks the smallest fire time < TIME_PERIOD; ties go to the lowest index.
  - winning_neuron and output_spike_time register the result. With no firing neuron they register NUM_NEURONS / TIME_PERIOD.
  - Outputs hold for the whole next window, giving one full window of latency.
- STDP, on the same end-of-window edge, only when training = 1 and a winner W exists. For each input i of neuron W only:
  - If spike_times[i] < TIME_PERIOD and spike_times[i] <= output time of W: w[W][i] + 1, saturating at 2^WBITS-1.
  - Otherwise (input silent or spiked later than W): w[W][i] - 1, saturating at 0.
- Non-winning neurons' weights are unchanged.
- spike_times and training are sampled every cycle. Callers keep spike_times stable for a window; changes mid-window take effect immediately.
- time_val values >= TIME_PERIOD are illegal; behaviour is then unspecified but must not corrupt weights out of range.

Optional Feature:
- Macro STDP_EN.
- Defined: STDP logic above is present.
- Undefined: weights are constants equal to their reset values; training is ignored (no update logic synthesised); inference is unchanged.

Test Plan:
- Reset:
  - Stimulus: rst_l=0.
  - Response: winning_neuron=4, output_spike_time=8.
  - After release with all spike_times=8 for one window: outputs stay 4/8.
- All inputs at time 0, training=0:
  - Every neuron's P = 56 >= 16 at time_val 0.
  - After the window: winning_neuron=0 (tie-break to lowest index), output_spike_time=0.
- Inputs 5, 6, 7 at time 3, others 8, training=0:
  - P = 18 / 3 / 12 / 13.
  - Response: winning_neuron=0, output_spike_time=3; weights unchanged.
- Same stimulus, training=1, one window:
  - w[0][5..7] become 6, 7, 7 (saturate).
  - Other w[0][i] decrement with saturation at 0 (w[0][0] stays 0, w[0][1] -> 0, w[0][4] -> 3).
  - Neurons 1-3 unchanged.
- Mid-window reset after training:
  - Stimulus: rst_l pulsed low at time_val=4.
  - Response: weights back to (i+3j) mod 8; outputs 4/8.
- STDP_EN undefined:
  - Stimulus: repeat the training scenario.
  - Response: weights unchanged, outputs identical to the inference run (0/3).
